// File: rtl/audioport_pkg.sv
// rtl/audioport_pkg.sv - shared audio port types and i2s_ctrl defaults
package audioport_pkg;

  localparam int I2S_CTRL_FIFO_DEPTH = 4;
  localparam int I2S_CTRL_PREFILL    = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREFILL,
    ST_PLAY,
    ST_DRAIN
  } i2s_ctrl_state_t;

  typedef struct packed {
    logic [23:0] left;
    logic [23:0] right;
  } stereo_pair_t;

endpackage

// File: rtl/i2s_ctrl_if.sv
// rtl/i2s_ctrl_if.sv - stereo-pair source stream into i2s_ctrl
interface i2s_ctrl_if;

  logic        src_valid_in;
  logic [23:0] src_audio0_in;
  logic [23:0] src_audio1_in;
  logic        src_ready_out;

  modport master (
    output src_valid_in, src_audio0_in, src_audio1_in,
    input  src_ready_out
  );

  modport slave (
    input  src_valid_in, src_audio0_in, src_audio1_in,
    output src_ready_out
  );

endinterface

// File: rtl/i2s_ctrl_fifo.sv
// rtl/i2s_ctrl_fifo.sv - synchronous stereo-pair FIFO, DEPTH a power of two
module i2s_ctrl_fifo
  import audioport_pkg::*;
#(
  parameter int DEPTH = I2S_CTRL_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  stereo_pair_t             wdata,
  input  logic                     pop,
  output stereo_pair_t             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  stereo_pair_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/i2s_ctrl.sv
// rtl/i2s_ctrl.sv - i2s_unit sequencer; I2S_CTRL_UNDERRUN_CNT_EN adds an underrun counter
module i2s_ctrl
  import audioport_pkg::*;
#(
  parameter int FIFO_DEPTH = I2S_CTRL_FIFO_DEPTH,
  parameter int PREFILL    = I2S_CTRL_PREFILL
) (
  input  logic        clk,
  input  logic        rst_n,
  i2s_ctrl_if.slave   src,
  input  logic        play_cmd_in,
  input  logic        cfg_cmd_in,
  input  logic [31:0] cfg_reg_in,
  input  logic        i2s_req_in,
  output logic        i2s_play_out,
  output logic        i2s_tick_out,
  output logic [23:0] i2s_audio0_out,
  output logic [23:0] i2s_audio1_out,
  output logic        i2s_cfg_out,
  output logic [31:0] i2s_cfg_reg_out,
  output logic        busy_out,
  output logic        underrun_out,
  output logic        cfg_err_out,
  output logic [15:0] underrun_count_out
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  i2s_ctrl_state_t state;
  stereo_pair_t    wr_pair;
  stereo_pair_t    rd_pair;
  logic [CW-1:0]   count;
  logic [CW-1:0]   cnt_nxt;
  logic            full, empty, push, serve, pop, start, prefill_ok;

  assign wr_pair    = {src.src_audio0_in, src.src_audio1_in};
  assign push       = src.src_valid_in && src.src_ready_out && (!full || pop);
  assign serve      = i2s_req_in && (state == ST_PLAY || state == ST_DRAIN);
  assign pop        = serve && !empty;
  assign start      = (state == ST_IDLE) && play_cmd_in;
  assign prefill_ok = (count >= CW'(PREFILL));
  assign cnt_nxt    = count + CW'(push) - CW'(pop);

  i2s_ctrl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wr_pair),
    .pop   (pop),
    .rdata (rd_pair),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      i2s_play_out      <= 1'b0;
      i2s_tick_out      <= 1'b0;
      i2s_audio0_out    <= '0;
      i2s_audio1_out    <= '0;
      i2s_cfg_out       <= 1'b0;
      i2s_cfg_reg_out   <= '0;
      busy_out          <= 1'b0;
      underrun_out      <= 1'b0;
      cfg_err_out       <= 1'b0;
      src.src_ready_out <= 1'b1;
    end else begin
      i2s_tick_out      <= serve;
      underrun_out      <= serve && empty && (state == ST_PLAY);
      i2s_cfg_out       <= cfg_cmd_in && (state == ST_IDLE);
      cfg_err_out       <= cfg_cmd_in && (state != ST_IDLE);
      src.src_ready_out <= (cnt_nxt < CW'(FIFO_DEPTH));
      // Play lags the state by one cycle so i2s_unit sees it after the transition.
      i2s_play_out      <= (state == ST_PLAY) || (state == ST_DRAIN);
      if (serve) begin
        i2s_audio0_out <= empty ? 24'd0 : rd_pair.left;
        i2s_audio1_out <= empty ? 24'd0 : rd_pair.right;
      end
      if (cfg_cmd_in && state == ST_IDLE) i2s_cfg_reg_out <= cfg_reg_in;

      case (state)
        ST_IDLE: begin
          if (play_cmd_in) begin
            state    <= prefill_ok ? ST_PLAY : ST_PREFILL;
            busy_out <= 1'b1;
          end
        end
        ST_PREFILL: begin
          if (!play_cmd_in) begin
            state    <= ST_IDLE;
            busy_out <= 1'b0;
          end else if (prefill_ok) begin
            state <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (!play_cmd_in) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (play_cmd_in) begin
            state <= ST_PLAY;
          end else if (empty && !i2s_req_in) begin
            state    <= ST_IDLE;
            busy_out <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

`ifdef I2S_CTRL_UNDERRUN_CNT_EN
  logic [15:0] urun_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      urun_cnt <= '0;
    end else if (start) begin
      urun_cnt <= '0;
    end else if (serve && empty && state == ST_PLAY && urun_cnt != 16'hFFFF) begin
      urun_cnt <= urun_cnt + 16'd1;
    end
  end

  assign underrun_count_out = urun_cnt;
`else
  assign underrun_count_out = '0;
`endif

endmodule

// File: doc/i2s_ctrl.md
# i2s_ctrl

Sequencing controller in front of `i2s_unit`. It buffers stereo sample pairs from the DSP path in a small FIFO, prefills before starting playback, and answers each `i2s_unit` request with a one-cycle tick plus sample pair. It muting-fills on underrun, drains cleanly on stop, and gates configuration loads so they only occur while playback is stopped.

## Interface
- `FIFO_DEPTH`, 4: stereo-pair FIFO depth; power of 2, ≥2.
- `PREFILL`, 2: pairs required in FIFO before playback starts; 1..FIFO_DEPTH.
- `clk` in 1: master clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `play_cmd_in` in 1: level; 1 = playback requested.
- `cfg_cmd_in` in 1: pulse; load `cfg_reg_in` into `i2s_unit`.
- `cfg_reg_in` in 32: configuration word.
- `src_valid_in` in 1: source pair valid.
- `src_audio0_in`, `src_audio1_in` in 24 each: left/right samples.
- `src_ready_out` out 1: FIFO not full.
- `i2s_req_in` in 1: `i2s_unit` req_out pulse.
- `i2s_play_out` out 1: to `i2s_unit` play_in.
- `i2s_tick_out` out 1: to tick_in.
- `i2s_audio0_out`, `i2s_audio1_out` out 24 each: to audio_in_0/1.
- `i2s_cfg_out` out 1: to cfg_in.
- `i2s_cfg_reg_out` out 32: to cfg_reg_in.
- `busy_out` out 1: state ≠ IDLE.
- `underrun_out` out 1: one-cycle pulse per underrun.
- `cfg_err_out` out 1: one-cycle pulse when `cfg_cmd_in` is rejected.
- `underrun_count_out` out 16: see Configuration.

## Operation
- FSM states: IDLE, PREFILL, PLAY, DRAIN.
- IDLE:
  - `cfg_cmd_in` → latch `cfg_reg_in` into `i2s_cfg_reg_out`; pulse `i2s_cfg_out` next cycle.
  - `play_cmd_in`=1 → PLAY if count ≥ PREFILL, else PREFILL.
- PREFILL: → PLAY when count ≥ PREFILL; → IDLE if `play_cmd_in`=0 (FIFO contents retained).
- PLAY:
  - `i2s_play_out`=1.
  - On `i2s_req_in`: pop one pair if FIFO non-empty; otherwise send 0/0 and pulse `underrun_out`.
  - `play_cmd_in`=0 → DRAIN.
- DRAIN:
  - `i2s_play_out`=1; requests are served from the FIFO.
  - Request with empty FIFO → 0/0 tick, no underrun.
  - → IDLE in the cycle after count = 0 with no tick pending.
  - `play_cmd_in`=1 → PLAY.
- `cfg_cmd_in` outside IDLE: ignored; pulse `cfg_err_out`; `i2s_cfg_reg_out` unchanged.
- FIFO:
  - Push when `src_valid_in & src_ready_out`, in any state.
  - Pop only on a serviced request.
  - Simultaneous push and pop when full is allowed; count is unchanged.

## Timing
- All outputs are registered.
- Reset values: all outputs 0, except `src_ready_out`=1. State = IDLE, FIFO empty, `i2s_cfg_reg_out`=0.
- `i2s_req_in` high at edge t → `i2s_tick_out`=1 for exactly cycle t+1, with audio outputs valid in the same cycle.
  - Audio outputs hold their value until the next tick.
- Back-to-back requests on consecutive cycles → back-to-back ticks with consecutive FIFO entries.
- `cfg_cmd_in` at t → `i2s_cfg_out`=1 during t+1 only.
- `cfg_err_out` and `underrun_out` are asserted in t+1.
- `i2s_play_out` rises in the cycle after entry to PLAY and falls in the cycle after entry to IDLE.
- Count width is log2(FIFO_DEPTH)+1; read and write pointers wrap modulo FIFO_DEPTH.
- `src_ready_out` = (count < FIFO_DEPTH), registered.
  - It deasserts in the cycle after the push that fills the FIFO.
- `rst_n` low mid-operation: immediate return to reset values; FIFO flushed; no tick emitted.

## Configuration
- `I2S_CTRL_UNDERRUN_CNT_EN` defined:
  - `underrun_count_out` is a 16-bit saturating counter of underrun pulses; saturates at 16'hFFFF.
  - Cleared by reset and on each IDLE→PREFILL/PLAY transition.
- Not defined: `underrun_count_out` is tied to 0 and no counter logic is generated.

## Structure
- Shared `audioport_pkg` holds:
  - `i2s_ctrl_state_t` enum (IDLE, PREFILL, PLAY, DRAIN);
  - `I2S_CTRL_FIFO_DEPTH` and `I2S_CTRL_PREFILL` defaults;
  - a packed 48-bit stereo-pair typedef.
- Sub-module `i2s_ctrl_fifo`: parameterized synchronous FIFO with push/pop/count/full/empty.
- FSM, tick generation, config gating and the counter live in `i2s_ctrl`.

## Test plan
- Config in IDLE: `cfg_cmd_in` pulse with `cfg_reg_in`=32'h0000_0005 → `i2s_cfg_out` high one cycle later with `i2s_cfg_reg_out`=5. The same pulse during PLAY → `cfg_err_out` pulse, register still 5.
- Prefill: `play_cmd_in`=1 with FIFO empty; push 1 pair → stays PREFILL with `i2s_play_out`=0. Push a 2nd pair → PLAY, and `i2s_play_out`=1 on the next cycle.
- Service: push pairs (1,2),(3,4) and enter PLAY; `i2s_req_in` pulses → ticks one cycle after each pulse carrying 1/2 then 3/4.
- Underrun: in PLAY with FIFO empty, `i2s_req_in` → tick with 0/0, `underrun_out` pulse. With the macro defined, `underrun_count_out` increments by 1 per underrun.
- Drain: 3 pairs queued, `play_cmd_in`→0 → three requests served; state returns to IDLE, `i2s_play_out`=0 after the last tick, and `busy_out`=0.
- Full and reset: push FIFO_DEPTH pairs with no requests → `src_ready_out`=0 and an extra push is ignored. Assert `rst_n`=0 mid-PLAY → all outputs return to reset values and the FIFO is empty.
